// File: rtl/crc_append.sv
// rtl/crc_append.sv - CRC-8 append framer for the SRAMC ingress packet path
//
// Takes a sop/eop-framed byte stream under a valid/ready handshake and re-emits
// it as: a standalone out_sop pulse, the data bytes, one CRC byte, then a
// standalone out_eop pulse. CRC is MSB-first with no reflection and no final XOR.
//
// Ports:
//   clk        clock, everything on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat valid
//   in_sop     first beat of a packet (only looked at while idle)
//   in_eop     last beat of a packet
//   in_data    upstream byte
//   in_ready   beat accepted this cycle (decoded from state only)
//   out_sop    one-cycle packet start pulse, no data
//   out_eop    one-cycle packet end pulse, no data
//   out_valid  out_data carries a data or CRC byte
//   out_data   output byte, holds its value between packets
//   len_err    pulses with the CRC byte when a packet was cut at MAX_LEN

module crc_append #(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   CRC_WIDTH  = 8,
  parameter logic [CRC_WIDTH-1:0] POLYNOMIAL = 8'h07,
  parameter logic [CRC_WIDTH-1:0] INIT_VALUE = 8'h00,
  parameter int                   MAX_LEN    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  len_err
);

  localparam int                   CNT_WIDTH = $clog2(MAX_LEN + 1);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOP,
    S_DATA,
    S_CRC,
    S_EOP
  } state_t;

  state_t                  state_q, state_d;
  logic [CRC_WIDTH-1:0]    crc_q, crc_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    trunc_q, trunc_d;
  logic                    out_sop_d, out_eop_d, out_valid_d, len_err_d;
  logic [DATA_WIDTH-1:0]   out_data_d;
  logic [CRC_WIDTH-1:0]    crc_upd;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  logic                    hs;

  // Bytewise CRC step: fold the byte in, then one shift per data bit.
  function automatic logic [CRC_WIDTH-1:0] crc_next(input logic [CRC_WIDTH-1:0] c,
                                                    input logic [DATA_WIDTH-1:0] d);
    logic [CRC_WIDTH-1:0] r;
    r = c ^ d;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (r[CRC_WIDTH-1]) r = (r << 1) ^ POLYNOMIAL;
      else                r = r << 1;
    end
    return r;
  endfunction

  assign in_ready = (state_q == S_SOP) || (state_q == S_DATA);
  assign hs       = in_valid && in_ready;
  // crc_q and cnt_q are reloaded on entry to S_SOP, so they already hold the
  // packet-start values when the first beat is taken.
  assign crc_upd  = crc_next(crc_q, in_data);
  assign cnt_inc  = cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    trunc_d     = trunc_q;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    out_valid_d = 1'b0;
    len_err_d   = 1'b0;
    out_data_d  = out_data;

    case (state_q)
      S_IDLE: begin
        // The cycle that carries out_eop is a turnaround cycle: a waiting
        // request is only taken once it has passed, leaving one quiet cycle
        // between out_eop and the next out_sop.
        if (in_valid && in_sop && !out_eop) begin
          state_d   = S_SOP;
          out_sop_d = 1'b1;
          crc_d     = INIT_VALUE;
          cnt_d     = '0;
          trunc_d   = 1'b0;
        end
      end

      S_SOP, S_DATA: begin
        if (hs) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          crc_d       = crc_upd;
          cnt_d       = cnt_inc;
          if (in_eop || (cnt_inc == MAX_CNT)) begin
            state_d = S_CRC;
            trunc_d = !in_eop;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_CRC: begin
        out_valid_d = 1'b1;
        out_data_d  = crc_q;
        len_err_d   = trunc_q;
        state_d     = S_EOP;
      end

      S_EOP: begin
        out_eop_d = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      crc_q     <= INIT_VALUE;
      cnt_q     <= '0;
      trunc_q   <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      len_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      trunc_q   <= trunc_d;
      out_sop   <= out_sop_d;
      out_eop   <= out_eop_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      len_err   <= len_err_d;
    end
  end

endmodule

// File: tb/tb_crc_append.sv
// tb/tb_crc_append.sv - scoreboard bench for crc_append
module tb_crc_append;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       in_valid, in_sop, in_eop;
  logic [7:0] in_data;

  logic       a_ready, a_sop, a_eop, a_valid, a_len;
  logic [7:0] a_data;
  logic       b_ready, b_sop, b_eop, b_valid, b_len;
  logic [7:0] b_data;

  logic       in_ready, out_sop, out_eop, out_valid, len_err;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  crc_append dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_sop(in_sop),
    .in_eop(in_eop), .in_data(in_data), .in_ready(a_ready), .out_sop(a_sop),
    .out_eop(a_eop), .out_valid(a_valid), .out_data(a_data), .len_err(a_len)
  );

  crc_append #(.MAX_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_sop(in_sop),
    .in_eop(in_eop), .in_data(in_data), .in_ready(b_ready), .out_sop(b_sop),
    .out_eop(b_eop), .out_valid(b_valid), .out_data(b_data), .len_err(b_len)
  );

  assign in_ready  = sel ? b_ready : a_ready;
  assign out_sop   = sel ? b_sop   : a_sop;
  assign out_eop   = sel ? b_eop   : a_eop;
  assign out_valid = sel ? b_valid : a_valid;
  assign out_data  = sel ? b_data  : a_data;
  assign len_err   = sel ? b_len   : a_len;

  // kind: 0 = sop pulse, 1 = data/CRC byte, 2 = eop pulse
  // gap:  required idle output cycles before this event, -1 = don't care
  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       len;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   idle_cyc = 0;
  int   rdy_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every output event against the head of the scoreboard.
  always @(negedge clk) begin
    if (in_ready) rdy_total++;
    if (out_sop || out_eop || out_valid) begin
      check("one_of_sop_eop_valid", int'(out_sop) + int'(out_eop) + int'(out_valid), 1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: sop=%0b eop=%0b valid=%0b data=%0h, expected none",
                 out_sop, out_eop, out_valid, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", out_sop ? 0 : (out_valid ? 1 : 2), mon_e.kind);
        if (mon_e.kind == 1) check("out_data", out_data, mon_e.data);
        check("len_err", len_err, mon_e.len);
        if (mon_e.gap >= 0) check("idle_gap", idle_cyc, mon_e.gap);
      end
      idle_cyc = 0;
    end else begin
      check("len_err_idle", len_err, 0);
      idle_cyc++;
    end
  end

  task automatic push(input int kind, input logic [7:0] d, input logic len, input int gap);
    exp_t e;
    e.kind = kind; e.data = d; e.len = len; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic go_idle(input int n);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until it is accepted (bounded).
  task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop);
    int w;
    w = 0;
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = d;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: in_ready=%0b, expected 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] b[$], input int stall_after, input int stall_len,
                          input logic [7:0] crc, input int first_gap);
    push(0, 8'h00, 1'b0, first_gap);
    for (int i = 0; i < b.size(); i++)
      push(1, b[i], 1'b0, (i == stall_after + 1) ? stall_len : 0);
    push(1, crc, 1'b0, 0);
    push(2, 8'h00, 1'b0, 0);
    for (int i = 0; i < b.size(); i++) begin
      send_beat(b[i], i == 0, i == b.size() - 1);
      if (i == stall_after) go_idle(stall_len);
    end
  endtask

  task automatic wait_empty();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

  logic [7:0] pkt[$];
  logic [7:0] pkt2[$];
  int         rdy_base;

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_sop", out_sop, 0);
    check("rst_out_eop", out_eop, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_len_err", len_err, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    go_idle(2);

    // single-byte packet, in_ready only during the SOP cycle
    rdy_base = rdy_total;
    pkt = '{8'h01};
    send_pkt(pkt, -1, 0, 8'h07, -1);
    go_idle(6);
    wait_empty();
    check("in_ready_cycles_1byte", rdy_total - rdy_base, 1);

    pkt = '{8'h01, 8'h02};
    send_pkt(pkt, -1, 0, 8'h1B, -1);
    go_idle(6);
    wait_empty();
    pkt = '{8'hFF};
    send_pkt(pkt, -1, 0, 8'hF3, -1);
    go_idle(6);
    wait_empty();
    pkt = '{8'h00};
    send_pkt(pkt, -1, 0, 8'h00, -1);
    go_idle(6);
    wait_empty();

    // "123456789" with a 2-cycle input stall after beat 4
    pkt = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_pkt(pkt, 3, 2, 8'hF4, -1);
    go_idle(6);
    wait_empty();

    // back-to-back: request held through EOP, second sop 2 cycles after eop
    pkt  = '{8'hFF};
    pkt2 = '{8'h01, 8'h02};
    send_pkt(pkt, -1, 0, 8'hF3, -1);
    send_pkt(pkt2, -1, 0, 8'h1B, 1);
    go_idle(6);
    wait_empty();

    // MAX_LEN=4 instance: 6 beats with no eop
    sel = 1'b1;
    go_idle(2);
    push(0, 8'h00, 1'b0, -1);
    push(1, 8'h01, 1'b0, 0);
    push(1, 8'h02, 1'b0, 0);
    push(1, 8'h03, 1'b0, 0);
    push(1, 8'h04, 1'b0, 0);
    push(1, 8'hE3, 1'b1, 0);
    push(2, 8'h00, 1'b0, 0);
    for (int i = 1; i <= 4; i++) send_beat(8'(i), i == 1, 1'b0);
    for (int i = 5; i <= 6; i++) begin
      in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'(i);
      repeat (3) begin
        @(negedge clk);
        check("in_ready_drop_beat", in_ready, 0);
        @(posedge clk);
        #1;
      end
    end
    go_idle(6);
    wait_empty();
    sel = 1'b0;
    go_idle(2);

    // reset in DATA after 3 bytes: no CRC/EOP, outputs cleared at once
    push(0, 8'h00, 1'b0, -1);
    push(1, 8'h10, 1'b0, 0);
    push(1, 8'h20, 1'b0, 0);
    push(1, 8'h30, 1'b0, 0);
    send_beat(8'h10, 1'b1, 1'b0);
    send_beat(8'h20, 1'b0, 1'b0);
    send_beat(8'h30, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_sop", out_sop, 0);
    check("abort_out_eop", out_eop, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_len_err", len_err, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_bytes_seen", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    go_idle(6);
    pkt = '{8'h01};
    send_pkt(pkt, -1, 0, 8'h07, -1);
    go_idle(6);
    wait_empty();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc_append.md
# crc_append

Transmit-side CRC-8 generator for the SRAMC ingress packet path. Accepts a byte stream framed by first/last markers under a valid/ready handshake and re-emits it in the SRAMC write framing: a standalone SOP pulse, the data bytes, one appended CRC byte, then a standalone EOP pulse. The SRAMC ingress CRC checker consumes this output directly. CRC model: CRC-8, poly 0x07, init 0x00, no input/output reflection, final XOR 0x00.

## Interface
- DATA_WIDTH, 8: byte width of in_data/out_data; must equal CRC_WIDTH.
- CRC_WIDTH, 8: CRC register width.
- POLYNOMIAL, 8'h07: generator polynomial, implicit x^8 term.
- INIT_VALUE, 8'h00: CRC register value at packet start.
- MAX_LEN, 256: maximum data beats per packet; forced termination beyond this.

- clk  in  1  single clock, all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_sop  in  1  qualifies the first beat of a packet.
- in_eop  in  1  qualifies the last beat of a packet.
- in_data  in  DATA_WIDTH  upstream byte.
- in_ready  out  1  block accepts the beat this cycle; handshake = in_valid & in_ready.
- out_sop  out  1  one-cycle packet start pulse, no data.
- out_eop  out  1  one-cycle packet end pulse, no data.
- out_valid  out  1  out_data carries a data or CRC byte.
- out_data  out  DATA_WIDTH  output byte.
- len_err  out  1  one-cycle pulse: packet forcibly terminated at MAX_LEN.

## Operation
- FSM states: IDLE, SOP, DATA, CRC, EOP. All outputs except in_ready are registered.
- in_ready = (state == SOP) || (state == DATA). It is combinational from state only and never depends on in_valid.
- IDLE: when in_valid & in_sop, go to SOP. The beat is not consumed; it is held upstream. in_valid without in_sop is dropped: in_ready stays 0 and the state does not change.
- SOP: out_sop=1 for this cycle. CRC register = INIT_VALUE, beat counter = 0. On handshake, go to DATA; otherwise stay in SOP with out_sop=0 after the first cycle.
- DATA: each handshake registers in_data onto out_data with out_valid=1 on the next cycle and updates the CRC. A cycle without a handshake gives out_valid=0 on the next cycle. in_sop is ignored inside a packet.
- CRC update per accepted byte: crc ^= in_data, then DATA_WIDTH iterations of: if crc[MSB], crc = (crc<<1) ^ POLYNOMIAL, else crc <<= 1. This is computed combinationally in one cycle.
- A handshake with in_eop=1 ends the packet: go to CRC.
- If the handshake is beat number MAX_LEN and in_eop=0, the beat is still the last one: go to CRC and pulse len_err on the same cycle as the CRC byte.
- CRC state: out_data = final CRC, out_valid=1, one cycle; then go to EOP.
- EOP state: out_eop=1, out_valid=0, one cycle; then go to IDLE.
- Between packets out_data holds its last value; only out_valid qualifies it.

## Timing
- Reset (async assert, sync release): state=IDLE, CRC=INIT_VALUE, counter=0.
- Reset values: out_sop=0, out_eop=0, out_valid=0, out_data=0, len_err=0, in_ready=0.
- Reset mid-packet aborts the packet; no CRC or EOP is emitted.
- Packet request seen at edge k: out_sop=1 during cycle k+1.
- First beat accepted in cycle k+1: out_valid=1 with that byte in cycle k+2.
- Latency from input handshake to output byte: 1 cycle.
- N-byte packet with no input gaps: out_sop, N data cycles, CRC cycle, out_eop cycle = N+3 cycles, then 1 IDLE cycle before the next out_sop.
- Minimum packet spacing: N+4 cycles.
- One-byte packet (in_sop & in_eop on the same beat) is legal: sop, data, CRC, eop.
- out_sop, out_eop and out_valid are never high in the same cycle.

## Test plan
- Reset, then packet {0x01} with in_sop=in_eop=1 -> output sequence: out_sop; out_valid with 0x01; out_valid with 0x07; out_eop. in_ready is high only in the SOP state cycle.
- Packet {0x01,0x02} -> CRC byte 0x1B. Packet {0xFF} -> CRC byte 0xF3. Packet {0x00} -> CRC byte 0x00.
- ASCII "123456789" (0x31..0x39) with in_valid deasserted for 2 cycles after beat 4 -> output bytes in order, out_valid low for exactly those 2 cycles, CRC byte 0xF4.
- Back-to-back packets with in_valid & in_sop held during EOP -> next out_sop exactly 2 cycles after out_eop. The second CRC is unaffected by the first packet.
- MAX_LEN=4, 6 beats without in_eop -> 4 data bytes output, then CRC of those 4, len_err pulse coincident with the CRC byte, then out_eop. The remaining beats arrive in IDLE without in_sop and are dropped.
- rst_n asserted during DATA after 3 bytes -> all outputs 0 immediately. No CRC or EOP is emitted. The next packet {0x01} again yields CRC 0x07.
